// File: rtl/eth_mii_pkg.sv
// Shared MII constants, CRC-32 parameters and framer state encoding.
// Imported by the TX framer, the CRC byte helper and the RX checker.
package eth_mii_pkg;

    localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  SFD_NIB      = 4'hd;

    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704_DD7B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_ERR,
        ST_IFG
    } tx_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational reflected CRC-32 update by one byte (LSB first).
// Ports: crc (current), data (byte), crc_next (updated register).
module eth_crc32_byte
    import eth_mii_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    always_comb begin
        crc_next = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            if (crc_next[0]) begin
                crc_next = (crc_next >> 1) ^ CRC_POLY;
            end else begin
                crc_next = crc_next >> 1;
            end
        end
    end

endmodule

// File: rtl/mii_tx_framer.sv
// Egress MII framer: byte stream in, preamble/SFD/data/pad/FCS/IFG out.
// Ports: clk, rstn, in_data/in_valid/in_last/in_ready stream,
// MII_TXD/MII_TX_EN/MII_TX_ER pins, busy, frame_done, underrun pulses.
module mii_tx_framer
    import eth_mii_pkg::*;
#(
    parameter int PREAMBLE_NIBBLES = 15,
    parameter int MIN_DATA_BYTES   = 60,
    parameter int IFG_NIBBLES      = 24,
    parameter int MAX_DATA_BYTES   = 1514
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [3:0] MII_TXD,
    output logic       MII_TX_EN,
    output logic       MII_TX_ER,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    tx_state_t   state;
    logic [4:0]  cnt;
    logic [7:0]  byte_q;
    logic        last_q;
    logic        hi_q;
    logic        oversize_q;
    logic [10:0] byte_cnt;
    logic [31:0] crc;

    logic        consume;
    logic        starve;
    logic [7:0]  crc_in;
    logic [31:0] crc_nxt;
    logic [10:0] cnt_inc;
    logic        at_max;
    logic        short_frame;

    // in_ready is registered, so the handshake is decided on the
    // cycle it is visible; padding feeds zero bytes into the CRC.
    always_comb begin
        consume     = in_ready & in_valid;
        starve      = in_ready & ~in_valid;
        crc_in      = consume ? in_data : 8'h00;
        cnt_inc     = (byte_cnt == 11'h7FF) ? byte_cnt
                                            : byte_cnt + 11'd1;
        at_max      = byte_cnt == 11'(MAX_DATA_BYTES - 1);
        short_frame = byte_cnt < 11'(MIN_DATA_BYTES);
    end

    eth_crc32_byte u_crc (
        .crc      (crc),
        .data     (crc_in),
        .crc_next (crc_nxt)
    );

    // state names the phase whose nibble is on MII_TXD this cycle;
    // each branch loads the outputs for the following cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            byte_q     <= '0;
            last_q     <= 1'b0;
            hi_q       <= 1'b0;
            oversize_q <= 1'b0;
            byte_cnt   <= '0;
            crc        <= CRC_INIT;
            in_ready   <= 1'b0;
            MII_TXD    <= 4'h0;
            MII_TX_EN  <= 1'b0;
            MII_TX_ER  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            in_ready   <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            if (starve) begin
                state     <= ST_ERR;
                MII_TXD   <= 4'h0;
                MII_TX_ER <= 1'b1;
                underrun  <= 1'b1;
            end else if (consume) begin
                state      <= ST_DATA;
                hi_q       <= 1'b0;
                byte_q     <= in_data;
                last_q     <= in_last | at_max;
                oversize_q <= at_max & ~in_last;
                byte_cnt   <= cnt_inc;
                crc        <= crc_nxt;
                MII_TXD    <= in_data[3:0];
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (in_valid) begin
                            state     <= ST_PRE;
                            cnt       <= '0;
                            MII_TXD   <= PREAMBLE_NIB;
                            MII_TX_EN <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    ST_PRE: begin
                        if (cnt == 5'(PREAMBLE_NIBBLES - 1)) begin
                            state      <= ST_SFD;
                            MII_TXD    <= SFD_NIB;
                            in_ready   <= 1'b1;
                            crc        <= CRC_INIT;
                            byte_cnt   <= '0;
                            oversize_q <= 1'b0;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    ST_DATA, ST_PAD: begin
                        if (!hi_q) begin
                            hi_q     <= 1'b1;
                            MII_TXD  <= (state == ST_DATA) ? byte_q[7:4]
                                                           : 4'h0;
                            in_ready <= (state == ST_DATA) & ~last_q;
                        end else if (short_frame) begin
                            state    <= ST_PAD;
                            hi_q     <= 1'b0;
                            MII_TXD  <= 4'h0;
                            byte_cnt <= cnt_inc;
                            crc      <= crc_nxt;
                        end else begin
                            // FCS leaves LSB nibble first; crc shifts
                            // down so the next nibble sits in [3:0].
                            state     <= ST_FCS;
                            cnt       <= '0;
                            MII_TXD   <= ~crc[3:0];
                            MII_TX_ER <= oversize_q;
                            crc       <= {4'h0, crc[31:4]};
                        end
                    end
                    ST_FCS: begin
                        if (cnt == 5'd7) begin
                            state     <= ST_IFG;
                            cnt       <= '0;
                            MII_TXD   <= 4'h0;
                            MII_TX_EN <= 1'b0;
                            MII_TX_ER <= 1'b0;
                        end else begin
                            cnt        <= cnt + 5'd1;
                            MII_TXD    <= ~crc[3:0];
                            crc        <= {4'h0, crc[31:4]};
                            frame_done <= cnt == 5'd6;
                        end
                    end
                    ST_ERR: begin
                        state     <= ST_IFG;
                        cnt       <= '0;
                        MII_TXD   <= 4'h0;
                        MII_TX_EN <= 1'b0;
                        MII_TX_ER <= 1'b0;
                    end
                    ST_IFG: begin
                        if (cnt == 5'(IFG_NIBBLES - 1)) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    // SFD always has in_ready high, so it is handled
                    // by the consume/starve paths above.
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mii_tx_framer.sv
// Randomized bench for mii_tx_framer against a frame-level model.
// Drives the byte stream, captures TX_EN bursts, compares nibbles.
module tb_mii_tx_framer;
    import eth_mii_pkg::*;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [3:0] nib_q_t[$];
    typedef struct {
        logic [7:0] d;
        logic       l;
    } stim_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [3:0] MII_TXD;
    logic       MII_TX_EN;
    logic       MII_TX_ER;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    always #5 clk = ~clk;

    mii_tx_framer dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .MII_TXD    (MII_TXD),
        .MII_TX_EN  (MII_TX_EN),
        .MII_TX_ER  (MII_TX_ER),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- cycle counter and burst monitor ----------------
    int     cyc = 0;
    always @(posedge clk) cyc++;

    bit     in_burst = 1'b0;
    nib_q_t nibs;
    nib_q_t last_nibs;
    int     er_cnt, er_first, last_er_cnt, last_er_first;
    int     bursts = 0;
    int     rise_cyc = 0, fall_cyc = -1000, gap = 0, last_gap = 0;
    int     busy_low_cyc = 0;
    int     fd_cnt = 0, ur_cnt = 0, ready_viol = 0;
    bit     prev_ready = 1'b0, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (MII_TX_EN) begin
            if (!in_burst) begin
                in_burst = 1'b1;
                nibs.delete();
                er_cnt   = 0;
                er_first = -1;
                rise_cyc = cyc;
                gap      = cyc - fall_cyc;
            end
            if (MII_TX_ER) begin
                if (er_first < 0) er_first = nibs.size();
                er_cnt++;
            end
            nibs.push_back(MII_TXD);
        end else if (in_burst) begin
            in_burst      = 1'b0;
            fall_cyc      = cyc;
            last_nibs     = nibs;
            last_er_cnt   = er_cnt;
            last_er_first = er_first;
            last_gap      = gap;
            bursts++;
        end
        if (prev_busy && !busy) busy_low_cyc = cyc;
        if (in_ready && prev_ready) ready_viol++;
        if (frame_done) fd_cnt++;
        if (underrun) ur_cnt++;
        prev_ready = in_ready;
        prev_busy  = busy;
    end

    // ---------------- reference model ----------------
    // Bit-serial Ethernet CRC: each bit enters LSB first.
    function automatic logic [31:0] crc_ref(input byte_q_t b);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (b[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[0] ^ b[k][i];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    function automatic nib_q_t frame_nibs(input byte_q_t body,
                                          input bit fcs);
        nib_q_t      q;
        byte_q_t     b;
        logic [31:0] f;
        b = body;
        repeat (15) q.push_back(4'h5);
        q.push_back(4'hd);
        if (fcs) while (b.size() < 60) b.push_back(8'h00);
        foreach (b[k]) begin
            q.push_back(b[k][3:0]);
            q.push_back(b[k][7:4]);
        end
        if (fcs) begin
            f = ~crc_ref(b);
            for (int i = 0; i < 8; i++) q.push_back(f[4*i +: 4]);
        end
        return q;
    endfunction

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t b;
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
        return b;
    endfunction

    function automatic byte_q_t head(input byte_q_t b, input int n);
        byte_q_t r;
        for (int i = 0; i < n; i++) r.push_back(b[i]);
        return r;
    endfunction

    // ---------------- stream driver ----------------
    stim_t stim[$];
    int    consumed = 0;
    int    valid_cyc = 0;
    bit    stop_drive = 1'b0;
    bit    drive_done = 1'b1;

    task automatic push_frame(input byte_q_t b, input bit use_last);
        stim_t s;
        foreach (b[k]) begin
            s.d = b[k];
            s.l = use_last && (k == b.size() - 1);
            stim.push_back(s);
        end
    endtask

    task automatic drive(input int drop_at, input int budget);
        int idx;
        bit fire;
        idx      = 0;
        consumed = 0;
        @(posedge clk);
        #1;
        valid_cyc = cyc;
        while (idx < stim.size() && idx != drop_at &&
               !stop_drive && budget > 0) begin
            in_valid = 1'b1;
            in_data  = stim[idx].d;
            in_last  = stim[idx].l;
            @(negedge clk);
            fire = in_ready;
            @(posedge clk);
            #1;
            budget--;
            if (fire) begin
                idx++;
                consumed++;
            end
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        stim.delete();
        drive_done = 1'b1;
    endtask

    task automatic launch(input int drop_at, input int budget);
        stop_drive = 1'b0;
        drive_done = 1'b0;
        fork
            drive(drop_at, budget);
        join_none
    endtask

    task automatic wait_bursts(input int target, input int limit,
                               input string tag);
        int n = 0;
        while (bursts < target && n < limit) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_burst_seen"}, 32'(bursts >= target), 32'd1);
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int n = 0;
        while ((busy || !drive_done) && n < limit) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(!busy && drive_done), 32'd1);
    endtask

    task automatic check_burst(input string tag, input nib_q_t exp);
        int errs = 0;
        int n;
        n = (last_nibs.size() < exp.size()) ? last_nibs.size()
                                            : exp.size();
        for (int i = 0; i < n; i++)
            if (last_nibs[i] !== exp[i]) errs++;
        chk({tag, "_len"}, 32'(last_nibs.size()), 32'(exp.size()));
        chk({tag, "_nib_errs"}, 32'(errs), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        byte_q_t     f, g, rx;
        nib_q_t      e;
        logic [31:0] c, rev;
        int          b0, fd0, ur0, n, len;

        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_txd", 32'(MII_TXD), 32'd0);
        chk("rst_en", 32'(MII_TX_EN), 32'd0);
        chk("rst_er", 32'(MII_TX_ER), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_ur", 32'(underrun), 32'd0);

        // Broadcast ARP, 60 bytes.
        f.delete();
        repeat (6) f.push_back(8'hff);
        for (int i = 0; i < 6; i++) f.push_back(8'(8'he0 + i));
        f.push_back(8'h08);
        f.push_back(8'h06);
        g = rand_bytes(46);
        foreach (g[k]) f.push_back(g[k]);
        push_frame(f, 1'b1);
        b0 = bursts; fd0 = fd_cnt;
        launch(-1, 1000);
        wait_bursts(b0 + 1, 400, "arp");
        check_burst("arp", frame_nibs(f, 1'b1));
        chk("arp_en_cycles", 32'(last_nibs.size()), 32'd144);
        chk("arp_latency", 32'(rise_cyc - valid_cyc), 32'd1);
        chk("arp_er", 32'(last_er_cnt), 32'd0);
        rx.delete();
        for (int k = 16; k + 1 < last_nibs.size(); k += 2)
            rx.push_back({last_nibs[k+1], last_nibs[k]});
        // The register after data+FCS is the bit-reversed residue.
        c   = crc_ref(rx);
        rev = {<<{c}};
        chk("arp_residue", rev, CRC_RESIDUE);
        wait_idle(100, "arp");
        chk("arp_fd", 32'(fd_cnt - fd0), 32'd1);
        chk("arp_ifg", 32'(busy_low_cyc - fall_cyc), 32'd24);

        // 14-byte header-only frame, padded with 46 zeros.
        f = rand_bytes(14);
        push_frame(f, 1'b1);
        b0 = bursts;
        launch(-1, 1000);
        wait_bursts(b0 + 1, 400, "hdr");
        check_burst("hdr", frame_nibs(f, 1'b1));
        chk("hdr_en_cycles", 32'(last_nibs.size()), 32'd144);
        wait_idle(100, "hdr");

        // Random lengths around the padding boundary.
        for (int t = 0; t < 5; t++) begin
            len = (t == 0) ? 1 : (t == 1) ? 60 : (t == 2) ? 61
                : int'($urandom_range(2, 150));
            f = rand_bytes(len);
            push_frame(f, 1'b1);
            b0 = bursts; fd0 = fd_cnt;
            launch(-1, 2000);
            wait_bursts(b0 + 1, 800, "rnd");
            n = (len < 60) ? 60 : len;
            check_burst($sformatf("rnd%0d", len), frame_nibs(f, 1'b1));
            chk("rnd_en_cycles", 32'(last_nibs.size()),
                32'(16 + 2 * n + 8));
            wait_idle(100, "rnd");
            chk("rnd_fd", 32'(fd_cnt - fd0), 32'd1);
        end

        // Two 100-byte frames with in_valid held high.
        f = rand_bytes(100);
        g = rand_bytes(100);
        push_frame(f, 1'b1);
        push_frame(g, 1'b1);
        b0 = bursts; fd0 = fd_cnt;
        launch(-1, 2000);
        wait_bursts(b0 + 1, 600, "b2b_a");
        check_burst("b2b_a", frame_nibs(f, 1'b1));
        chk("b2b_a_cycles", 32'(last_nibs.size()), 32'd224);
        wait_bursts(b0 + 2, 600, "b2b_b");
        check_burst("b2b_b", frame_nibs(g, 1'b1));
        chk("b2b_b_cycles", 32'(last_nibs.size()), 32'd224);
        chk("b2b_gap_ok", 32'(last_gap >= 25), 32'd1);
        wait_idle(100, "b2b");
        chk("b2b_fd", 32'(fd_cnt - fd0), 32'd2);

        // Underrun at byte 30 of a 200-byte frame.
        f = rand_bytes(200);
        push_frame(f, 1'b1);
        b0 = bursts; fd0 = fd_cnt; ur0 = ur_cnt;
        launch(30, 2000);
        wait_bursts(b0 + 1, 600, "urun");
        e = frame_nibs(head(f, 30), 1'b0);
        e.push_back(4'h0);
        check_burst("urun", e);
        chk("urun_er_cnt", 32'(last_er_cnt), 32'd1);
        chk("urun_er_pos", 32'(last_er_first), 32'd76);
        wait_idle(100, "urun");
        chk("urun_pulse", 32'(ur_cnt - ur0), 32'd1);
        chk("urun_fd", 32'(fd_cnt - fd0), 32'd0);
        chk("urun_ifg", 32'(busy_low_cyc - fall_cyc), 32'd24);
        f = rand_bytes(64);
        push_frame(f, 1'b1);
        b0 = bursts;
        launch(-1, 1000);
        wait_bursts(b0 + 1, 400, "post_urun");
        check_burst("post_urun", frame_nibs(f, 1'b1));
        wait_idle(100, "post_urun");

        // Reset asserted while byte 40 is in flight.
        f = rand_bytes(100);
        push_frame(f, 1'b1);
        launch(-1, 2000);
        n = 0;
        while (consumed < 40 && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("mrst_reach40", 32'(consumed >= 40), 32'd1);
        rstn = 1'b0;
        #1;
        chk("mrst_en", 32'(MII_TX_EN), 32'd0);
        chk("mrst_txd", 32'(MII_TXD), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd0);
        stop_drive = 1'b1;
        n = 0;
        while (!drive_done && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("mrst_idle_en", 32'(MII_TX_EN), 32'd0);
        f = rand_bytes(64);
        push_frame(f, 1'b1);
        b0 = bursts;
        launch(-1, 1000);
        wait_bursts(b0 + 1, 400, "post_rst");
        check_burst("post_rst", frame_nibs(f, 1'b1));
        wait_idle(100, "post_rst");

        // Oversize: 1600 bytes, never flagged last.
        f = rand_bytes(1600);
        push_frame(f, 1'b0);
        b0 = bursts; fd0 = fd_cnt;
        launch(-1, 5000);
        wait_bursts(b0 + 1, 4000, "ovs");
        stop_drive = 1'b1;
        check_burst("ovs", frame_nibs(head(f, 1514), 1'b1));
        chk("ovs_er_cnt", 32'(last_er_cnt), 32'd8);
        chk("ovs_er_pos", 32'(last_er_first), 32'd3044);
        wait_idle(100, "ovs");
        chk("ovs_consumed", 32'(consumed), 32'd1514);
        chk("ovs_fd", 32'(fd_cnt - fd0), 32'd1);
        chk("ovs_ifg", 32'(busy_low_cyc - fall_cyc), 32'd24);

        chk("ready_consec", 32'(ready_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mii_tx_framer.md
# mii_tx_framer

Egress MII framer for one switch port: takes a byte-wide frame stream from the port's output buffer and drives the 4-bit MII transmit interface. Each frame goes out as 15 preamble nibbles, the SFD nibble and the data with padding, followed by the generated FCS and the interframe gap. It is the transmit counterpart of the port's MII receive path and sits between the egress queue and the `MII_TXD_n/MII_TX_EN_n/MII_TX_ER_n` pins of `top_switch`.

## Interface
- `PREAMBLE_NIBBLES`, 15: count of 4'h5 nibbles before the SFD.
- `MIN_DATA_BYTES`, 60: minimum DA..payload length; shorter frames are zero-padded to this length.
- `IFG_NIBBLES`, 24: idle cycles after the FCS (96 bit times).
- `MAX_DATA_BYTES`, 1514: longest frame accepted without FCS.

Ports:
- `clk` in 1: MII TX clock. One nibble is sent per cycle.
- `rstn` in 1: reset, asynchronous, active-low.
- `in_data` in 8: frame byte. The first byte is DA[47:40].
- `in_valid` in 1: `in_data` is valid.
- `in_last` in 1: marks the final byte of the frame.
- `in_ready` out 1: byte is consumed when `in_valid && in_ready`.
- `MII_TXD` out 4: transmit nibble.
- `MII_TX_EN` out 1: transmit enable.
- `MII_TX_ER` out 1: transmit error.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `frame_done` out 1: one-cycle pulse on the last FCS nibble.
- `underrun` out 1: one-cycle pulse when a frame is aborted because data was late.

## Operation
- FSM states: IDLE, PRE, SFD, DATA, PAD, FCS, ERR, IFG.
- IDLE:
  - `in_valid`=1 moves to PRE. The byte is not consumed yet.
  - `in_ready`=0 in IDLE.
- PRE: `TXD`=4'h5 for `PREAMBLE_NIBBLES` cycles, then SFD.
- SFD:
  - `TXD`=4'hd for 1 cycle.
  - `in_ready`=1, which consumes byte 0.
- DATA:
  - Each byte takes 2 cycles: low nibble `[3:0]` first, then `[7:4]`.
  - `in_ready`=1 on the high-nibble cycle; this consumes the next byte.
  - CRC is updated once per byte.
  - After a byte flagged `in_last`:
    - byte count < `MIN_DATA_BYTES`: go to PAD;
    - otherwise: go to FCS.
- PAD: sends 8'h00 bytes (2 nibbles each, CRC updated) until the count reaches `MIN_DATA_BYTES`, then goes to FCS.
- FCS: sends `~crc` as 8 nibbles, `[3:0]` first through `[31:28]`. On the 8th nibble, pulses `frame_done` and goes to IFG.
- CRC:
  - Reflected CRC-32, polynomial 32'hEDB88320.
  - Initialised to 32'hFFFFFFFF at SFD.
  - Covers DA through pad.
- Underrun: on an `in_ready` cycle with `in_valid`=0 during DATA:
  - next cycle: ERR, with `TX_EN`=1, `TX_ER`=1, `TXD`=0 for 1 cycle, and `underrun` pulses;
  - then IFG.
  - The upstream block flushes the rest of that frame.
- Oversize: if byte `MAX_DATA_BYTES` is consumed without `in_last`, it is treated as last. All 8 FCS nibbles are then sent with `TX_ER`=1.
- IFG: `TX_EN`=0 for `IFG_NIBBLES` cycles, then IDLE.
- Byte counter: 11 bits, saturating, cleared at SFD.

## Timing
- All outputs are registered.
- Reset values: `MII_TXD`=0, `MII_TX_EN`=0, `MII_TX_ER`=0, `in_ready`=0, `busy`=0, `frame_done`=0, `underrun`=0; FSM in IDLE.
- Latency: `in_valid` seen in IDLE at cycle t, so `TX_EN`=1 with `TXD`=5 at t+1. The SFD appears at t+16 and byte 0's low nibble at t+17.
- `TX_EN` high time: 16 + 2·max(N,60) + 8 cycles. For N≤60 this is 144 cycles.
- Back-to-back frames: the falling edge of `TX_EN` to the next rising edge is at least `IFG_NIBBLES`+1 cycles. A waiting `in_valid` must not shorten this gap.
- `in_ready` is never high on two consecutive cycles.
- `rstn` low mid-frame: all outputs drop to their reset values immediately and the FSM returns to IDLE. No IFG is enforced after reset.

## Structure
- Package `eth_mii_pkg` holds:
  - `PREAMBLE_NIB`=4'h5, `SFD_NIB`=4'hd;
  - `CRC_INIT`=32'hFFFFFFFF, `CRC_POLY`=32'hEDB88320, `CRC_RESIDUE`=32'hC704DD7B;
  - the FSM state typedef.
- Sub-module `eth_crc32_byte`: a combinational byte update, `crc_next = f(crc, byte)`. It is shared with the receive checker.

## Test plan
- Broadcast ARP, 60 bytes:
  - stimulus: DA ff..ff, SA e0e1e2e3e4e5, type 0806;
  - response: `TXD` shows 15×5, then d, then 120 data nibbles, then 8 FCS nibbles;
  - CRC-32 over data+FCS equals 32'hC704DD7B;
  - `TX_EN` is high for exactly 144 cycles.
- 14-byte header-only frame:
  - 46 zero pad bytes are appended;
  - `TX_EN` is high for 144 cycles;
  - the FCS matches a reference model over 60 bytes.
- Two 100-byte frames with `in_valid` held high:
  - each burst has `TX_EN` high for 224 cycles;
  - the gap between bursts is ≥25 cycles;
  - `frame_done` pulses twice.
- Underrun:
  - stimulus: `in_valid` dropped at byte 30 of a 200-byte frame;
  - response: one cycle of `TX_EN`=1, `TX_ER`=1, then `TX_EN`=0;
  - `underrun` pulses once, and the next frame starts correctly after the IFG.
- Reset mid-frame:
  - stimulus: `rstn`=0 at byte 40;
  - response: `TX_EN`=0 within the same edge;
  - after release, a new 64-byte frame transmits correctly.
- Oversize:
  - stimulus: 1600 bytes with no `in_last`;
  - response: 1514 bytes are consumed, the FCS is sent with `TX_ER`=1, then IFG.
